// File: rtl/soc_trace_collector.sv
// soc_trace_collector: decodes per-core writeback trace events, queues them per core and merges them round-robin onto one stream
module soc_trace_collector #(
    parameter int NUM_CORES  = 4,
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ENABLE_EXC = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_CORES-1:0]                                enable,
    input  logic [NUM_CORES*XLEN-1:0]                           wb_pc,
    input  logic [NUM_CORES*32-1:0]                             wb_insn,
    input  logic [NUM_CORES*XLEN-1:0]                           r3,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [(NUM_CORES > 1 ? $clog2(NUM_CORES) : 1)-1:0]  out_core,
    output logic [2:0]                                          out_type,
    output logic [15:0]                                         out_code,
    output logic [XLEN-1:0]                                     out_data,
    output logic [NUM_CORES*16-1:0]                             overflow_count,
    output logic [NUM_CORES-1:0]                                terminated,
    output logic                                                all_terminated
);
    localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 19 + XLEN;

    logic [XLEN-1:0]      w_pc    [NUM_CORES];
    logic [31:0]          w_insn  [NUM_CORES];
    logic [XLEN-1:0]      w_r3    [NUM_CORES];
    logic [EW-1:0]        w_ev_pl [NUM_CORES];
    logic [NUM_CORES-1:0] w_q, w_nop, w_exc, w_rfe, w_ev, w_term_set;
    logic [NUM_CORES-1:0] w_full, w_ne, w_push, w_drop, w_pop;
    logic [3:0]           r_prev  [NUM_CORES];
    logic [AW-1:0]        r_wp    [NUM_CORES];
    logic [AW-1:0]        r_rp    [NUM_CORES];
    logic [AW:0]          r_cnt   [NUM_CORES];
    logic [15:0]          r_ovf   [NUM_CORES];
    logic [EW-1:0]        r_mem   [NUM_CORES][FIFO_DEPTH];
    logic [NUM_CORES-1:0] r_term;
    logic [CW-1:0]        r_last;
    logic [CW-1:0]        w_sel;
    logic                 w_any;
    logic                 w_load;
    logic [EW-1:0]        w_head;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign w_pc[g]       = wb_pc[g*XLEN +: XLEN];
        assign w_insn[g]     = wb_insn[g*32 +: 32];
        assign w_r3[g]       = r3[g*XLEN +: XLEN];
        assign w_q[g]        = enable[g] & ~r_term[g];
        assign w_nop[g]      = w_insn[g][31:16] == 16'h1500;
        assign w_exc[g]      = ~w_nop[g] && w_pc[g][XLEN-1:12] == '0 && w_pc[g][7:0] == 8'h00 &&
                               w_pc[g][11:8] != r_prev[g];
        assign w_rfe[g]      = w_insn[g] == 32'h2400_0000 && !w_exc[g];
        assign w_ev[g]       = w_q[g] & ((w_nop[g] & |w_insn[g][15:0]) |
                                         ((ENABLE_EXC != 0) & (w_exc[g] | w_rfe[g])));
        assign w_term_set[g] = w_q[g] & w_nop[g] & (w_insn[g][15:0] == 16'h0001);
        assign w_ev_pl[g]    = w_nop[g] ? {w_insn[g][15:0] == 16'h0001 ? 3'd0 :
                                           w_insn[g][15:0] == 16'h0004 ? 3'd1 : 3'd2,
                                           w_insn[g][15:0], w_r3[g]} :
                               w_exc[g] ? {3'd3, 12'h000, w_pc[g][11:8], w_pc[g]} :
                                          {3'd4, 16'h0000, w_pc[g]};
        assign w_full[g]     = r_cnt[g] == (AW+1)'(FIFO_DEPTH);
        assign w_ne[g]       = r_cnt[g] != '0;
        assign w_push[g]     = w_ev[g] & ~w_full[g];
        assign w_drop[g]     = w_ev[g] & w_full[g];
        assign w_pop[g]      = w_load && (w_sel == CW'(g));
        assign overflow_count[g*16 +: 16] = r_ovf[g];
    end

    assign terminated     = r_term;
    assign all_terminated = &r_term;
    assign w_load         = w_any & (~out_valid | out_ready);
    assign w_head         = r_mem[w_sel][r_rp[w_sel]];

    // round-robin search for the first non-empty FIFO after the last granted core
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!w_any && w_ne[(int'(r_last) + k) % NUM_CORES]) begin
                w_any = 1'b1;
                w_sel = CW'((int'(r_last) + k) % NUM_CORES);
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (w_push[i]) r_mem[i][r_wp[i]] <= w_ev_pl[i];
    end

    // per-core pointers, occupancy, previous vector, drop counters and termination flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_prev[i] <= '0;
                r_wp[i]   <= '0;
                r_rp[i]   <= '0;
                r_cnt[i]  <= '0;
                r_ovf[i]  <= '0;
            end
            r_term <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_q[i]) r_prev[i] <= w_pc[i][11:8];
                if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i]) r_rp[i] <= r_rp[i] + 1'b1;
                r_cnt[i] <= r_cnt[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
                if (w_drop[i] && r_ovf[i] != 16'hFFFF) r_ovf[i] <= r_ovf[i] + 16'd1;
            end
            r_term <= r_term | w_term_set;
        end
    end

    // output register: refill whenever free or being consumed, else drop valid on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_core  <= '0;
            out_type  <= '0;
            out_code  <= '0;
            out_data  <= '0;
            r_last    <= CW'(NUM_CORES - 1);
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_core  <= w_sel;
            out_type  <= w_head[EW-1 -: 3];
            out_code  <= w_head[XLEN +: 16];
            out_data  <= w_head[XLEN-1:0];
            r_last    <= w_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
